// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin issue sequencer for one compute block's
// per-thread register file. It accepts a launch (thread count, block index),
// rotates the read-context select over live threads, delays every issued
// thread ID through a WB_LAT-deep writeback tracker, and handles thread exit,
// kernel drain and a one-cycle completion pulse.
//
// Optional feature: define THREAD_SCHED_BARRIER_EN to build the block-wide
// barrier (arrived mask plus release). When it is undefined the barrier input
// is ignored and every live thread is always eligible.

module thread_scheduler #(
  parameter int NUM_THREADS = 16,
  parameter int TID_W       = 5,
  parameter int WB_LAT      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             launch_valid,
  output logic             launch_ready,
  input  logic [TID_W-1:0] launch_count,
  input  logic [31:0]      launch_bidx,
  input  logic             stall,
  input  logic             thread_exit,
  input  logic             barrier,
  output logic             issue_valid,
  output logic [TID_W-1:0] thread_read,
  output logic             wb_valid,
  output logic [TID_W-1:0] thread_write,
  output logic [31:0]      bIdx,
  output logic             busy,
  output logic             kernel_done
);

  // Bits needed to index a thread context inside the live masks.
  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  // One-hot marker of the oldest (tail) writeback slot.
  localparam logic [WB_LAT-1:0] TAIL_BIT = WB_LAT'(1) << (WB_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [NUM_THREADS-1:0] active_reg;
  logic [NUM_THREADS-1:0] active_next;
  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] launch_mask;
  logic [TID_W-1:0]       ptr_reg;
  logic [TID_W-1:0]       ptr_next;
  logic                   issue_valid_reg;
  logic [31:0]            bidx_reg;
  logic                   kernel_done_reg;
  logic                   fire;

  // Writeback tracker: stage 0 is the head, stage WB_LAT-1 is the tail.
  logic [WB_LAT-1:0]      wb_v_reg;
  logic [TID_W-1:0]       wb_t_reg [WB_LAT];
  logic                   wb_upstream_busy;

`ifdef THREAD_SCHED_BARRIER_EN
  logic [NUM_THREADS-1:0] arrived_reg;
  logic [NUM_THREADS-1:0] arrived_next;
`else
  // Barrier hint has no meaning without the barrier logic.
  logic unused_barrier;
  assign unused_barrier = barrier;
`endif

  // An issue only fires in RUN on a non-stalled cycle; issue_valid_reg is
  // high exactly while in RUN.
  assign fire = issue_valid_reg && !stall;

  // Launch mask: the lowest launch_count contexts are live. Counts above
  // NUM_THREADS saturate naturally because the mask has only NUM_THREADS bits.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_launch_mask
      assign launch_mask[gi] = (32'(gi) < 32'(launch_count));
    end
  endgenerate

  // Apply this cycle's exit/barrier to the masks and derive the eligible set,
  // releasing the barrier when every live thread has arrived.
  always_comb begin
    active_next = active_reg;
    if (fire && thread_exit) begin
      active_next[ptr_reg[IDX_W-1:0]] = 1'b0;
    end
`ifdef THREAD_SCHED_BARRIER_EN
    arrived_next = arrived_reg;
    // Exit takes priority over a barrier on the same instruction.
    if (fire && barrier && !thread_exit) begin
      arrived_next[ptr_reg[IDX_W-1:0]] = 1'b1;
    end
    elig = active_next & ~arrived_next;
    if ((active_next != '0) && (elig == '0)) begin
      arrived_next = '0;
      elig         = active_next;
    end
`else
    elig = active_next;
`endif
  end

  // Round-robin pick: lowest eligible index above ptr, else wrap to the
  // lowest eligible index; hold ptr if nothing is eligible (kernel ending).
  always_comb begin
    logic             hi_found;
    logic             lo_found;
    logic [TID_W-1:0] hi_idx;
    logic [TID_W-1:0] lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (elig[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = TID_W'(i);
      end
      if (elig[i] && !hi_found && (32'(i) > 32'(ptr_reg))) begin
        hi_found = 1'b1;
        hi_idx   = TID_W'(i);
      end
    end
    if (hi_found) begin
      ptr_next = hi_idx;
    end else if (lo_found) begin
      ptr_next = lo_idx;
    end else begin
      ptr_next = ptr_reg;
    end
  end

  // Writeback tracker stages: shift on every non-stalled cycle, head takes
  // {fire, ptr} so the write select lines up with the retiring instruction.
  generate
    for (gi = 0; gi < WB_LAT; gi++) begin : g_wb_stage
      if (gi == 0) begin : g_head
        // Head stage captures the current issue slot.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            wb_v_reg[gi] <= 1'b0;
            wb_t_reg[gi] <= '0;
          end else if (!stall) begin
            wb_v_reg[gi] <= fire;
            wb_t_reg[gi] <= ptr_reg;
          end
        end
      end else begin : g_body
        // Body stage advances the previous stage's entry.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            wb_v_reg[gi] <= 1'b0;
            wb_t_reg[gi] <= '0;
          end else if (!stall) begin
            wb_v_reg[gi] <= wb_v_reg[gi-1];
            wb_t_reg[gi] <= wb_t_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Any valid entry ahead of the tail means the pipeline is not empty after
  // the next shift (no new issues enter during DRAIN).
  assign wb_upstream_busy = |(wb_v_reg & ~TAIL_BIT);

  // Kernel control FSM with registered issue/done/bIdx outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      active_reg      <= '0;
      ptr_reg         <= '0;
      issue_valid_reg <= 1'b0;
      bidx_reg        <= '0;
      kernel_done_reg <= 1'b0;
`ifdef THREAD_SCHED_BARRIER_EN
      arrived_reg     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (launch_valid && (launch_count != '0)) begin
            active_reg      <= launch_mask;
            ptr_reg         <= '0;
            bidx_reg        <= launch_bidx;
            issue_valid_reg <= 1'b1;
            state           <= S_RUN;
`ifdef THREAD_SCHED_BARRIER_EN
            arrived_reg     <= '0;
`endif
          end
        end
        S_RUN: begin
          if (fire) begin
            active_reg <= active_next;
            ptr_reg    <= ptr_next;
`ifdef THREAD_SCHED_BARRIER_EN
            arrived_reg <= arrived_next;
`endif
            if (active_next == '0) begin
              issue_valid_reg <= 1'b0;
              state           <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Leave once the tail entry retires on this non-stalled shift.
          if (!stall && !wb_upstream_busy) begin
            kernel_done_reg <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          kernel_done_reg <= 1'b0;
          state           <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign launch_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign issue_valid  = issue_valid_reg;
  assign thread_read  = ptr_reg;
  assign wb_valid     = wb_v_reg[WB_LAT-1];
  assign thread_write = wb_t_reg[WB_LAT-1];
  assign bIdx         = bidx_reg;
  assign kernel_done  = kernel_done_reg;

endmodule
